// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings, clear-sequencer states and byte-enable helper
// shared by the data memory and its load extender.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, READY} clr_state_t;

    // Zero means the encoding/lane pair cannot be served.
    function automatic logic [3:0] byte_en(input logic [2:0] ctrl, input logic [1:0] lane);
        return (ctrl == F3_B || ctrl == F3_BU) ? 4'b0001 << lane :
               (ctrl == F3_H || ctrl == F3_HU) ? (lane == 2'd0 ? 4'b0011 :
                                                  lane == 2'd2 ? 4'b1100 : 4'b0000) :
               (ctrl == F3_W && lane == 2'd0)  ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// load_extend: picks the addressed byte/half of a word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = 8'(word_i >> {lane_i, 3'b000});
        h      = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = ctrl_i == F3_B  ? {{24{b[7]}}, b} :
                 ctrl_i == F3_BU ? {24'b0, b} :
                 ctrl_i == F3_H  ? {{16{h[15]}}, h} :
                 ctrl_i == F3_HU ? {16'b0, h} :
                 ctrl_i == F3_W  ? word_i : 32'b0;
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable data RAM with extended loads, misalignment
// detection, sticky error flag and a post-reset clear sweep.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        dm_en,
    input  logic        dm_write,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] dm_data_wr,
    output logic [31:0] dm_data_rd,
    output logic        busy,
    output logic        misaligned,
    output logic        dm_err
);

    logic [3:0][7:0]  mem [DEPTH_WORDS];
    clr_state_t       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d, idx, wr_idx;
    logic             dm_err_q, dm_err_d, legal;
    logic [1:0]       lane;
    logic [3:0]       be, wr_be;
    logic [31:0]      st_data, wr_data, rd_word, ext;
    logic             unused_addr;

    assign unused_addr = ^address[31:IDX_W+2];

    always_comb begin
        idx        = address[IDX_W+1:2];
        lane       = address[1:0];
        be         = byte_en(dm_ctrl, lane);
        // Unsigned store encodings share byte enables with loads but are illegal.
        legal      = (be != 4'b0000) && !(dm_write && dm_ctrl[2]);
        busy       = state_q == CLEAR;
        misaligned = dm_en && !busy && !legal;
        st_data    = dm_ctrl == F3_B ? {4{dm_data_wr[7:0]}} :
                     dm_ctrl == F3_H ? {2{dm_data_wr[15:0]}} : dm_data_wr;
        wr_idx     = busy ? clr_idx_q : idx;
        wr_be      = rst ? 4'b0000 : busy ? 4'b1111 :
                     (dm_en && dm_write && legal) ? be : 4'b0000;
        wr_data    = busy ? 32'b0 : st_data;
        rd_word    = mem[idx];
        dm_data_rd = (dm_en && !dm_write && !busy && legal) ? ext : 32'b0;
        state_d    = rst ? CLEAR :
                     (busy && clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) ? READY : state_q;
        clr_idx_d  = rst ? '0 : busy ? clr_idx_q + IDX_W'(1) : clr_idx_q;
        dm_err_d   = !rst && (dm_err_q || misaligned);
        dm_err     = dm_err_q;
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        dm_err_q  <= dm_err_d;
        for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
    end

    load_extend u_load_extend (
        .word_i (rd_word),
        .ctrl_i (dm_ctrl),
        .lane_i (lane),
        .data_o (ext)
    );

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of sweep, stores, extended loads,
// misalignment, illegal encodings, wrap and reset behaviour (16 words).
module tb_data_memory;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] address = '0, dm_data_wr = '0;
    logic        dm_en = 1'b0, dm_write = 1'b0;
    logic [2:0]  dm_ctrl = '0;
    logic [31:0] dm_data_rd;
    logic        busy, misaligned, dm_err;
    int          pass = 0, total = 0;

    data_memory #(.DEPTH_WORDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .dm_en      (dm_en),
        .dm_write   (dm_write),
        .dm_ctrl    (dm_ctrl),
        .dm_data_wr (dm_data_wr),
        .dm_data_rd (dm_data_rd),
        .busy       (busy),
        .misaligned (misaligned),
        .dm_err     (dm_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dm_en    = 1'b0;
        dm_write = 1'b0;
    endtask

    task automatic pulse_rst();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        address = a; dm_data_wr = d; dm_ctrl = c; dm_en = 1'b1; dm_write = 1'b1;
        tick();
        idle();
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] c);
        address = a; dm_ctrl = c; dm_en = 1'b1; dm_write = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else pass++;
        total++; if (dm_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", dm_err); else pass++;
        address = 32'h41; dm_ctrl = 3'b010; dm_en = 1'b1;
        #1;
        total++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", misaligned); else pass++;
        total++; if (dm_data_rd !== 32'h0) $display("FAIL reset_rd: got %h expected 0", dm_data_rd); else pass++;
        idle();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 5) begin
                address = 32'h0; dm_data_wr = 32'hDEADBEEF; dm_ctrl = 3'b010;
                dm_en = 1'b1; dm_write = 1'b1;
            end else idle();
            tick();
            n++;
        end
        idle();
        total++; if (n !== 16) $display("FAIL sweep_len: got %0d expected 16", n); else pass++;
        total++; if (dm_err !== 1'b0) $display("FAIL sweep_err: got %b expected 0", dm_err); else pass++;
        for (int i = 0; i < 16; i++) begin
            ld(32'(i * 4), 3'b010);
            total++; if (dm_data_rd !== 32'h0) $display("FAIL cleared_w%0d: got %h expected 0", i, dm_data_rd); else pass++;
        end
        idle();
    endtask

    task automatic test_byte_half();
        st(32'h40, 32'h11223344, 3'b010);
        ld(32'h40, 3'b010);
        total++; if (dm_data_rd !== 32'h11223344) $display("FAIL sw_lw: got %h expected 11223344", dm_data_rd); else pass++;
        total++; if (misaligned !== 1'b0) $display("FAIL lw_aligned: got %b expected 0", misaligned); else pass++;
        st(32'h41, 32'hAAAAAA80, 3'b000);
        ld(32'h40, 3'b010);
        total++; if (dm_data_rd !== 32'h11228044) $display("FAIL sb_lw: got %h expected 11228044", dm_data_rd); else pass++;
        ld(32'h41, 3'b000);
        total++; if (dm_data_rd !== 32'hFFFFFF80) $display("FAIL lb: got %h expected ffffff80", dm_data_rd); else pass++;
        ld(32'h41, 3'b100);
        total++; if (dm_data_rd !== 32'h00000080) $display("FAIL lbu: got %h expected 00000080", dm_data_rd); else pass++;
        st(32'h42, 32'h1234BEEF, 3'b001);
        ld(32'h42, 3'b001);
        total++; if (dm_data_rd !== 32'hFFFFBEEF) $display("FAIL lh: got %h expected ffffbeef", dm_data_rd); else pass++;
        ld(32'h42, 3'b101);
        total++; if (dm_data_rd !== 32'h0000BEEF) $display("FAIL lhu: got %h expected 0000beef", dm_data_rd); else pass++;
        ld(32'h40, 3'b010);
        total++; if (dm_data_rd !== 32'hBEEF8044) $display("FAIL sh_lw: got %h expected beef8044", dm_data_rd); else pass++;
        ld(32'h40, 3'b001);
        total++; if (dm_data_rd !== 32'hFFFF8044) $display("FAIL lh_lo: got %h expected ffff8044", dm_data_rd); else pass++;
        ld(32'h43, 3'b000);
        total++; if (dm_data_rd !== 32'hFFFFFFBE) $display("FAIL lb_hi: got %h expected ffffffbe", dm_data_rd); else pass++;
        ld(32'h40, 3'b100);
        total++; if (dm_data_rd !== 32'h00000044) $display("FAIL lbu_lo: got %h expected 00000044", dm_data_rd); else pass++;
        idle();
    endtask

    task automatic test_misaligned();
        address = 32'h41; dm_ctrl = 3'b010; dm_en = 1'b1; dm_write = 1'b0;
        #1;
        total++; if (misaligned !== 1'b1) $display("FAIL lw_mis_flag: got %b expected 1", misaligned); else pass++;
        total++; if (dm_data_rd !== 32'h0) $display("FAIL lw_mis_rd: got %h expected 0", dm_data_rd); else pass++;
        tick();
        idle();
        total++; if (dm_err !== 1'b1) $display("FAIL err_set: got %b expected 1", dm_err); else pass++;
        tick();
        total++; if (dm_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", dm_err); else pass++;
        st(32'h43, 32'h00005555, 3'b001);
        ld(32'h40, 3'b010);
        total++; if (dm_data_rd !== 32'hBEEF8044) $display("FAIL sh_mis_nowrite: got %h expected beef8044", dm_data_rd); else pass++;
        idle();
    endtask

    task automatic test_illegal();
        int n;
        pulse_rst();
        count_busy(n);
        total++; if (dm_err !== 1'b0) $display("FAIL rst_clears_err: got %b expected 0", dm_err); else pass++;
        st(32'h44, 32'h01020304, 3'b010);
        address = 32'h44; dm_data_wr = 32'hFFFFFFFF; dm_ctrl = 3'b011; dm_en = 1'b1; dm_write = 1'b1;
        #1;
        total++; if (misaligned !== 1'b1) $display("FAIL st011_flag: got %b expected 1", misaligned); else pass++;
        tick();
        idle();
        total++; if (dm_err !== 1'b1) $display("FAIL st011_err: got %b expected 1", dm_err); else pass++;
        ld(32'h44, 3'b010);
        total++; if (dm_data_rd !== 32'h01020304) $display("FAIL st011_nowrite: got %h expected 01020304", dm_data_rd); else pass++;
        st(32'h44, 32'hFFFFFFFF, 3'b101);
        ld(32'h44, 3'b010);
        total++; if (dm_data_rd !== 32'h01020304) $display("FAIL st101_nowrite: got %h expected 01020304", dm_data_rd); else pass++;
        ld(32'h44, 3'b110);
        total++; if (dm_data_rd !== 32'h0) $display("FAIL ld110_rd: got %h expected 0", dm_data_rd); else pass++;
        total++; if (misaligned !== 1'b1) $display("FAIL ld110_flag: got %b expected 1", misaligned); else pass++;
        idle();
    endtask

    task automatic test_wrap();
        st(32'h80, 32'hA5A5A5A5, 3'b010);
        ld(32'h40, 3'b010);
        total++; if (dm_data_rd !== 32'hA5A5A5A5) $display("FAIL wrap: got %h expected a5a5a5a5", dm_data_rd); else pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        address = 32'h40; dm_data_wr = 32'h12345678; dm_ctrl = 3'b010; dm_en = 1'b1; dm_write = 1'b0;
        #1;
        total++; if (dm_data_rd !== 32'hA5A5A5A5) $display("FAIL same_cycle_old: got %h expected a5a5a5a5", dm_data_rd); else pass++;
        dm_write = 1'b1;
        #1;
        total++; if (dm_data_rd !== 32'h0) $display("FAIL store_rd_zero: got %h expected 0", dm_data_rd); else pass++;
        tick();
        dm_write = 1'b0;
        #1;
        total++; if (dm_data_rd !== 32'h12345678) $display("FAIL next_cycle_new: got %h expected 12345678", dm_data_rd); else pass++;
        idle();
        st(32'h48, 32'hCAFEF00D, 3'b010);
        st(32'h4C, 32'h0BADC0DE, 3'b010);
        ld(32'h48, 3'b010);
        total++; if (dm_data_rd !== 32'hCAFEF00D) $display("FAIL b2b_w2: got %h expected cafef00d", dm_data_rd); else pass++;
        ld(32'h4C, 3'b010);
        total++; if (dm_data_rd !== 32'h0BADC0DE) $display("FAIL b2b_w3: got %h expected 0badc0de", dm_data_rd); else pass++;
        idle();
    endtask

    task automatic test_reset_mid();
        int n;
        ld(32'h42, 3'b010);
        idle();
        total++; if (dm_err !== 1'b1) $display("FAIL mid_err_set: got %b expected 1", dm_err); else pass++;
        pulse_rst();
        total++; if (dm_err !== 1'b0) $display("FAIL mid_err_clr: got %b expected 0", dm_err); else pass++;
        total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else pass++;
        for (int i = 0; i < 9; i++) tick();
        pulse_rst();
        count_busy(n);
        total++; if (n !== 16) $display("FAIL restart_len: got %0d expected 16", n); else pass++;
        ld(32'h48, 3'b010);
        total++; if (dm_data_rd !== 32'h0) $display("FAIL restart_cleared: got %h expected 0", dm_data_rd); else pass++;
        idle();
    endtask

    initial begin
        test_reset();
        test_byte_half();
        test_misaligned();
        test_illegal();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
